// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  localparam int DIV_STEPS = 32;

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_ctrl_div_step.sv
// One restoring-divide iteration: trial subtract, keep or restore.
// Latency: combinational.
// Backpressure: none; evaluated whenever the sequencer is in DIV.
module div_step (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] diff;

  always_comb begin
    diff    = {1'b0, rem_in} - {2'b00, divisor};
    q_bit   = ~diff[33];
    rem_out = q_bit ? diff[32:0] : rem_in;
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: single-pass multiply, 32-step restoring divide, MTHI/MTLO.
// Latency: multiply commits 2 cycles after accept, divide 34 cycles after accept.
// Backpressure: stall holds EXE from the request cycle until the commit cycle.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DIV_STEPS = hilo_pkg::DIV_STEPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic        is_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  mthl,
  input  logic        exc_flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;   // a_q doubles as the dividend/quotient shift register
  logic [31:0] rem_q;
  logic [5:0]  cnt_q;
  logic        sgn_q, q_neg_q, r_neg_q;
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic [63:0] a_ext, b_ext, product;
  logic [32:0] step_rem;
  logic        step_q;
  logic        rem_unused;
  logic [31:0] quo_fix, rem_fix;

  assign accept = (state_q == IDLE) && op_valid && !exc_flush &&
                  ((op == OP_MUL) || (op == OP_DIV));

  div_step u_div_step (
    .rem_in  ({rem_q, a_q[31]}),
    .divisor (b_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The partial remainder never reaches the divisor, so its top bit stays zero.
  assign rem_unused = step_rem[32];

  always_comb begin
    a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
    b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
    product = a_ext * b_ext;
    quo_fix = q_neg_q ? -a_q : a_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (op == OP_MUL) ? MUL : DIV;
      end
      MUL:  state_d = DONE;
      DIV:  if (cnt_q == 6'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (exc_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (accept) begin
      sgn_q <= is_signed;
      rem_q <= '0;
      cnt_q <= 6'(DIV_STEPS - 1);
      if ((op == OP_DIV) && is_signed) begin
        a_q     <= abs32(src_a);
        b_q     <= abs32(src_b);
        q_neg_q <= src_a[31] ^ src_b[31];
        r_neg_q <= src_a[31];
      end else begin
        a_q     <= src_a;
        b_q     <= src_b;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
      end
    end else if (state_q == DIV) begin
      rem_q <= step_rem[31:0];
      a_q   <= {a_q[30:0], step_q};
      if (cnt_q != 6'd0) cnt_q <= cnt_q - 6'd1;
    end
  end

  // Commits are dropped when an exception flush lands on the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state_q == MUL) && !exc_flush) begin
      hi_q <= product[63:32];
      lo_q <= product[31:0];
    end else if ((state_q == FIX) && !exc_flush) begin
      hi_q <= rem_fix;
      lo_q <= quo_fix;
    end else if (state_q == IDLE) begin
      if (mthl[1]) hi_q <= src_a;
      if (mthl[0]) lo_q <= src_a;
    end
  end

  assign stall = accept || (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign busy  = (state_q != IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
